// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default configuration for the multi-port register file.
//   rf_state_t  - sweep/ready state of the register file
//   *_DEFAULT   - default parameter values used by regfile_mp and rf_scoreboard
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_CLEAR,
    RF_READY
  } rf_state_t;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam int unsigned NREGS_DEFAULT    = 32;
  localparam int unsigned NRD_DEFAULT      = 2;
  localparam int unsigned NWR_DEFAULT      = 2;
  localparam bit          ZERO_REG_DEFAULT = 1'b1;

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending bits for issue-stage hazard checks.
//   clk_i, rst_i    - clock, synchronous active-high reset (clears all pending bits)
//   upd_en_i        - updates allowed (register file ready)
//   set_en_i/addr_i - mark a destination pending
//   wr_en_i/addr_i  - writeback ports; each enabled port clears its address
//   rd_addr_i       - lookup addresses, one per read port
//   pend_o          - stored pending bit for each lookup address
module rf_scoreboard import regfile_pkg::*; #(
  parameter int unsigned NREGS    = NREGS_DEFAULT,
  parameter int unsigned NWR      = NWR_DEFAULT,
  parameter int unsigned NRD      = NRD_DEFAULT,
  parameter bit          ZERO_REG = ZERO_REG_DEFAULT,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              upd_en_i,
  input  logic              set_en_i,
  input  logic [AW-1:0]     set_addr_i,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD-1:0]    pend_o
);

  logic [NREGS-1:0] pend_q, pend_d;

  // Clears are applied before the set so that a set to the same address wins.
  always_comb begin
    pend_d = pend_q;
    if (upd_en_i) begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_en_i[i]) pend_d[wr_addr_i[i*AW +: AW]] = 1'b0;
      end
      if (set_en_i) pend_d[set_addr_i] = 1'b1;
    end
    if (ZERO_REG) pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  always_comb begin
    pend_o = '0;
    for (int r = 0; r < NRD; r++) begin
      pend_o[r] = pend_q[rd_addr_i[r*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with same-cycle write bypass,
// post-reset clear sweep and a pending scoreboard.
//   clk, rst                 - clock, synchronous active-high reset (restarts the sweep)
//   wr_en/wr_addr/wr_data    - NWR write ports; highest-index port wins on collision
//   rd_addr/rd_data/rd_pend  - NRD combinational read ports with bypass and pending flag
//   sb_set_en/sb_set_addr    - mark a destination register pending
//   busy                     - clear sweep in progress; writes and sets ignored
module regfile_mp import regfile_pkg::*; #(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter int unsigned NREGS    = NREGS_DEFAULT,
  parameter int unsigned NRD      = NRD_DEFAULT,
  parameter int unsigned NWR      = NWR_DEFAULT,
  parameter bit          ZERO_REG = ZERO_REG_DEFAULT,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pend,
  input  logic                sb_set_en,
  input  logic [AW-1:0]       sb_set_addr,
  output logic                busy
);

  localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

  rf_state_t       state_q;
  logic [AW-1:0]   idx_q;
  logic            busy_q;
  logic [XLEN-1:0] mem_q [NREGS];

  logic [NRD-1:0]  byp_hit;
  logic [NRD-1:0]  rd_zero;
  logic [NRD-1:0]  sb_pend;

  assign busy = busy_q;

  // Sweep controller; busy is a registered copy of "state is RF_CLEAR".
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      idx_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        RF_CLEAR: begin
          if (idx_q == LastIdx) begin
            state_q <= RF_READY;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        RF_READY: begin
          busy_q <= 1'b0;
        end
        default: begin
          state_q <= RF_CLEAR;
          idx_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Storage: sweep writes zero; ports are applied in ascending order so the
  // highest-index port's assignment is the one that lands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == RF_CLEAR) begin
        mem_q[idx_q] <= '0;
      end else begin
        for (int w = 0; w < NWR; w++) begin
          if (wr_en[w] && !(ZERO_REG && wr_addr[w*AW +: AW] == '0)) begin
            mem_q[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
          end
        end
      end
    end
  end

  // Read ports: stored value, overridden by matching writes (last match = highest
  // port), then forced to zero for the zero register and during the sweep.
  always_comb begin
    rd_data = '0;
    byp_hit = '0;
    rd_zero = '0;
    for (int r = 0; r < NRD; r++) begin
      rd_data[r*XLEN +: XLEN] = mem_q[rd_addr[r*AW +: AW]];
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && wr_addr[w*AW +: AW] == rd_addr[r*AW +: AW]) begin
          rd_data[r*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
          byp_hit[r] = 1'b1;
        end
      end
      rd_zero[r] = busy_q || (ZERO_REG && rd_addr[r*AW +: AW] == '0);
      if (rd_zero[r]) rd_data[r*XLEN +: XLEN] = '0;
    end
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .NWR      (NWR),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i      (clk),
    .rst_i      (rst),
    .upd_en_i   (state_q == RF_READY),
    .set_en_i   (sb_set_en),
    .set_addr_i (sb_set_addr),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .rd_addr_i  (rd_addr),
    .pend_o     (sb_pend)
  );

  // A same-cycle write to the address resolves the hazard, matching the bypass.
  assign rd_pend = sb_pend & ~byp_hit & ~rd_zero;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;
  localparam int BX = 64, BN = 16, BRD = 3, BWR = 1, BAW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-configuration DUT
  logic                rst;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_pend;
  logic                sb_set_en;
  logic [AW-1:0]       sb_set_addr;
  logic                busy;

  // Alternate configuration: wide, shallow, single write port, writable reg 0
  logic              b_rst;
  logic [BWR-1:0]    b_wr_en;
  logic [BWR*BAW-1:0] b_wr_addr;
  logic [BWR*BX-1:0] b_wr_data;
  logic [BRD*BAW-1:0] b_rd_addr;
  logic [BRD*BX-1:0] b_rd_data;
  logic [BRD-1:0]    b_rd_pend;
  logic              b_busy;

  regfile_mp dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_pend     (rd_pend),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .busy        (busy)
  );

  regfile_mp #(
    .XLEN     (BX),
    .NREGS    (BN),
    .NRD      (BRD),
    .NWR      (BWR),
    .ZERO_REG (1'b0)
  ) dut_b (
    .clk         (clk),
    .rst         (b_rst),
    .wr_en       (b_wr_en),
    .wr_addr     (b_wr_addr),
    .wr_data     (b_wr_data),
    .rd_addr     (b_rd_addr),
    .rd_data     (b_rd_data),
    .rd_pend     (b_rd_pend),
    .sb_set_en   (1'b0),
    .sb_set_addr ('0),
    .busy        (b_busy)
  );

  // Reference model of the default DUT
  logic [XLEN-1:0] m_mem [NREGS];
  bit              m_pend [NREGS];
  bit              m_busy;
  int              m_idx;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input int p);
    int a = int'(rd_addr[p*AW +: AW]);
    if (m_busy || a == 0) return '0;
    for (int w = NWR - 1; w >= 0; w--)
      if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) return wr_data[w*XLEN +: XLEN];
    return m_mem[a];
  endfunction

  function automatic logic exp_pend(input int p);
    int a = int'(rd_addr[p*AW +: AW]);
    if (m_busy || a == 0) return 1'b0;
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_busy = 1'b1;
      m_idx  = 0;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
    end else if (m_busy) begin
      m_mem[m_idx] = '0;
      if (m_idx == NREGS - 1) m_busy = 1'b0;
      else m_idx++;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        int a = int'(wr_addr[w*AW +: AW]);
        if (wr_en[w] && a != 0) begin
          m_mem[a]  = wr_data[w*XLEN +: XLEN];
          m_pend[a] = 1'b0;
        end
      end
      if (sb_set_en && sb_set_addr != '0) m_pend[sb_set_addr] = 1'b1;
    end
  endtask

  // Outputs are checked mid-cycle, then the edge is taken and the model advanced.
  task automatic settle();
    #4;
    chk("busy", 64'(busy), 64'(m_busy));
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("rd_data[%0d]", p), 64'(rd_data[p*XLEN +: XLEN]), 64'(exp_rd(p)));
      chk($sformatf("rd_pend[%0d]", p), 64'(rd_pend[p]), 64'(exp_pend(p)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic cyc_expect(input string tag, input logic [XLEN-1:0] d, input logic pd);
    settle();
    chk({tag, "_data"}, 64'(rd_data[XLEN-1:0]), 64'(d));
    chk({tag, "_pend"}, 64'(rd_pend[0]), 64'(pd));
    tick();
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    sb_set_en = 1'b0; sb_set_addr = '0;
  endtask

  task automatic set_wr(input int w, input int a, input logic [XLEN-1:0] d);
    wr_en[w] = 1'b1;
    wr_addr[w*AW +: AW] = AW'(a);
    wr_data[w*XLEN +: XLEN] = d;
  endtask

  task automatic sweep_len(input string tag, input int exp);
    int cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cyc();
      cnt++;
    end
    chk(tag, 64'(cnt), 64'(exp));
  endtask

  initial begin
    idle();
    rst = 1'b1;
    rd_addr = '0;
    b_rst = 1'b1; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;
    tick();
    cyc();
    rst = 1'b0;
    sweep_len("sweep_initial", NREGS);

    // Preload reg 5, then a one-cycle reset pulse must wipe it.
    set_wr(0, 5, 32'hDEADBEEF);
    rd_addr[AW-1:0] = 5'd5;
    cyc_expect("preload_byp", 32'hDEADBEEF, 1'b0);
    idle();
    cyc_expect("preload_st", 32'hDEADBEEF, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sweep_len("sweep_pulse", NREGS);
    cyc_expect("reg5_cleared", 32'h0, 1'b0);

    // Reset re-asserted at sweep index 10 restarts from index 0.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (10) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sweep_len("sweep_restart", NREGS);

    // Write-port collision: highest port wins, both bypassed and stored.
    set_wr(0, 7, 32'h11);
    set_wr(1, 7, 32'h22);
    rd_addr[AW-1:0] = 5'd7;
    cyc_expect("coll_byp", 32'h22, 1'b0);
    idle();
    cyc_expect("coll_st", 32'h22, 1'b0);

    // Bypass and zero register.
    set_wr(0, 3, 32'hA5A5A5A5);
    rd_addr[AW-1:0] = 5'd3;
    cyc_expect("byp_reg3", 32'hA5A5A5A5, 1'b0);
    idle();
    set_wr(1, 0, 32'hFFFF);
    rd_addr[AW-1:0] = 5'd0;
    cyc_expect("zero_byp", 32'h0, 1'b0);
    idle();
    cyc_expect("zero_st", 32'h0, 1'b0);

    // Scoreboard set, same-cycle clear view, and set-beats-clear.
    sb_set_en = 1'b1; sb_set_addr = 5'd9;
    rd_addr[AW-1:0] = 5'd9;
    cyc_expect("sb_set_now", 32'h0, 1'b0);
    idle();
    cyc_expect("sb_set_next", 32'h0, 1'b1);
    set_wr(1, 9, 32'h99);
    cyc_expect("sb_wb_now", 32'h99, 1'b0);
    idle();
    cyc_expect("sb_wb_next", 32'h99, 1'b0);
    set_wr(0, 9, 32'h77);
    sb_set_en = 1'b1; sb_set_addr = 5'd9;
    cyc_expect("sb_both_now", 32'h77, 1'b0);
    idle();
    cyc_expect("sb_both_next", 32'h77, 1'b1);

    // Writes and sets during the sweep are dropped.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (10) cyc();
    set_wr(0, 4, 32'h1234);
    sb_set_en = 1'b1; sb_set_addr = 5'd4;
    cyc();
    idle();
    sweep_len("sweep_gated", NREGS - 11);
    rd_addr[AW-1:0] = 5'd4;
    cyc_expect("gated_reg4", 32'h0, 1'b0);

    // Randomised traffic, biased toward low addresses for collisions.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int w = 0; w < NWR; w++) begin
        wr_en[w] = ($urandom_range(0, 2) != 0);
        wr_addr[w*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NREGS - 1)
                                                            : $urandom_range(0, 7));
        wr_data[w*XLEN +: XLEN] = $urandom;
      end
      for (int p = 0; p < NRD; p++)
        rd_addr[p*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NREGS - 1)
                                                            : $urandom_range(0, 7));
      sb_set_en = ($urandom_range(0, 2) == 0);
      sb_set_addr = AW'($urandom_range(0, 7));
      cyc();
    end
    idle();

    // Alternate configuration: 16-cycle sweep, writable reg 0, 64-bit data.
    b_rst = 1'b0;
    begin
      int cnt = 0;
      while (b_busy === 1'b1 && cnt < 100) begin
        cyc();
        cnt++;
      end
      chk("b_sweep_len", 64'(cnt), 64'(BN));
    end
    b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_data = 64'h1; b_rd_addr = '0;
    settle();
    for (int p = 0; p < BRD; p++) begin
      chk($sformatf("b_reg0_byp[%0d]", p), b_rd_data[p*BX +: BX], 64'h1);
      chk($sformatf("b_pend[%0d]", p), 64'(b_rd_pend[p]), 64'h0);
    end
    tick();
    b_wr_en = 1'b1; b_wr_addr = 4'd15; b_wr_data = 64'hFEDC_BA98_7654_3210;
    cyc();
    b_wr_en = 1'b0;
    b_rd_addr = {4'd15, 4'd0, 4'd0};
    settle();
    chk("b_reg0_st0", b_rd_data[0*BX +: BX], 64'h1);
    chk("b_reg0_st1", b_rd_data[1*BX +: BX], 64'h1);
    chk("b_reg15_st", b_rd_data[2*BX +: BX], 64'hFEDC_BA98_7654_3210);
    chk("b_busy_low", 64'(b_busy), 64'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
